// File: rtl/vga_fb_fetch_arbiter.sv
// Frame-buffer fetch arbiter: shares one single-port memory between the display
// line prefetcher (always wins) and a drawing-client write port.
module vga_fb_fetch_arbiter #(
    parameter int H_DISPLAY  = 800,
    parameter int V_DISPLAY  = 600,
    parameter int H_TOTAL    = 1056,
    parameter int V_TOTAL    = 628,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        wr_req,
    input  logic [16:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_gnt,
    output logic        mem_en,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  pixel,
    output logic        de,
    output logic        underflow,
    output logic [1:0]  fsm_state
);
    localparam int WPL = H_DISPLAY / 4;
    localparam int WCW = $clog2(WPL + 1);
    localparam int OW  = $clog2(FIFO_DEPTH);
    localparam logic [10:0]    H_DISP_L  = 11'(H_DISPLAY);
    localparam logic [10:0]    H_TOT_L   = 11'(H_TOTAL);
    localparam logic [9:0]     V_DISP_L  = 10'(V_DISPLAY);
    localparam logic [9:0]     V_LAST_L  = 10'(V_TOTAL - 1);
    localparam logic [16:0]    WPL_L     = 17'(WPL);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WPL - 1);
    localparam logic [OW+1:0]  DEPTH_L   = (OW + 2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, FETCH = 2'd2} state_t;
    state_t state, state_next;

    logic           flush_second;
    logic [16:0]    fetch_addr;
    logic [WCW-1:0] word_cnt;
    logic           rd_pend;
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [OW-1:0]  wr_ptr, rd_ptr;
    logic [OW:0]    occ;
    logic [23:0]    sr;

    logic           trigger, rd_issue, wr_issue, active, pop_slot, fifo_empty, push, pop;
    logic [9:0]     next_line;
    logic [16:0]    line_base;
    logic [1:0]     inflight;
    logic [OW+1:0]  fill;
    logic [31:0]    head;

    assign fsm_state = state;

    // Handshake: the writer holds wr_req/wr_addr/wr_data until wr_gnt. wr_gnt pulses in
    // the cycle the write is on the memory bus; a request still seen while wr_gnt is high
    // is the one just issued, so it is never issued twice.
    always_comb begin
        trigger    = (hcount == H_DISP_L) && (hcount < H_TOT_L) &&
                     ((vcount < V_DISP_L - 10'd1) || (vcount == V_LAST_L));
        next_line  = (vcount == V_LAST_L) ? 10'd0 : vcount + 10'd1;
        line_base  = {7'd0, next_line} * WPL_L;
        inflight   = {1'b0, mem_en & ~mem_we} + {1'b0, rd_pend};
        fill       = {1'b0, occ} + {{OW{1'b0}}, inflight};
        rd_issue   = (state == FETCH) && (fill < DEPTH_L);
        wr_issue   = !rd_issue && wr_req && !wr_gnt;
        active     = (hcount < H_DISP_L) && (vcount < V_DISP_L);
        pop_slot   = active && (hcount[1:0] == 2'd0);
        fifo_empty = (occ == '0);
        push       = rd_pend && (state != FLUSH);
        pop        = pop_slot && !fifo_empty && (state != FLUSH);
        head       = fifo_mem[rd_ptr];

        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = FLUSH;
            FLUSH:   if (flush_second) state_next = FETCH;
            FETCH:   if (rd_issue && (word_cnt == LAST_WORD)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            flush_second <= 1'b0;
        end else begin
            state        <= state_next;
            flush_second <= (state == FLUSH) && !flush_second;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr <= '0;
            word_cnt   <= '0;
        end else if ((state == IDLE) && trigger) begin
            fetch_addr <= line_base;
        end else if (state == FLUSH) begin
            word_cnt <= '0;
        end else if (rd_issue) begin
            fetch_addr <= fetch_addr + 17'd1;
            word_cnt   <= word_cnt + WCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_gnt    <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            mem_en  <= rd_issue | wr_issue;
            mem_we  <= wr_issue;
            wr_gnt  <= wr_issue;
            rd_pend <= mem_en & ~mem_we;
            if (rd_issue) begin
                mem_addr <= fetch_addr;
            end else if (wr_issue) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

    // Read data landing during FLUSH belongs to an abandoned fetch and is dropped.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (state == FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + OW'(1);
            if (pop)  rd_ptr <= rd_ptr + OW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (OW + 1)'(1);
                2'b01:   occ <= occ - (OW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel     <= '0;
            de        <= 1'b0;
            underflow <= 1'b0;
            sr        <= '0;
        end else begin
            de <= active;
            if (!active) begin
                pixel <= '0;
            end else if (pop_slot) begin
                if (fifo_empty || (state == FLUSH)) begin
                    pixel     <= '0;
                    sr        <= '0;
                    underflow <= 1'b1;
                end else begin
                    pixel <= head[7:0];
                    sr    <= head[31:8];
                end
            end else begin
                pixel <= sr[7:0];
                sr    <= {8'd0, sr[23:8]};
            end
            if (state == FLUSH) sr <= '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Bench for vga_fb_fetch_arbiter: drives the H/V counters line by line over a
// behavioural RAM and compares every output cycle against a line-queue model.
module tb_vga_fb_fetch_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt, mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [7:0]  pixel;
    logic        de, underflow;
    logic [1:0]  fsm_state;

    vga_fb_fetch_arbiter dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pixel(pixel), .de(de), .underflow(underflow),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural single-port RAM, read data one cycle after the read strobe
    logic [31:0] mem [0:131071];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        else mem_rdata <= $urandom;
    end

    typedef struct { int y; int x; logic [7:0] pix; } vec_t;
    vec_t vecs [15];
    logic [7:0] obs [0:4][0:799];

    // reference model and scoreboard state
    logic [31:0] line_q[$];
    logic [48:0] exp_q[$];
    logic [31:0] cur_word;
    logic [7:0]  e_pix;
    logic        e_de, e_uf;
    logic [16:0] exp_rd_addr;
    int          rd_count;
    bit          fetch_ok, prev_gnt, writer_on, directed_pending, capture_on;
    logic [10:0] ap_h;
    logic [9:0]  ap_v;
    int          n_cmp, n_err;
    int          lines [12] = '{626, 627, 0, 1, 2, 3, 4, 598, 599, 600, 627, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (h=%0d v=%0d)", name, act, exp, ap_h, ap_v);
        end
    endtask

    task automatic new_request();
        logic [16:0] a;
        logic [31:0] d;
        if (directed_pending) begin
            a = 17'd200;
            d = 32'hAABBCCDD;
            directed_pending = 1'b0;
        end else begin
            if ($urandom_range(1, 0) == 1) a = 17'($urandom_range(131071, 120000));
            else a = 17'($urandom_range(119000, 1200));
            d = $urandom;
        end
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        exp_q.push_back({a, d});
    endtask

    // Whole-line view: a trigger queues the full next line; each active group of 4
    // pixels takes one word, or zeros plus a sticky underflow if none is left.
    task automatic model_apply(input logic [10:0] h, input logic [9:0] v);
        int nl;
        if (h == 11'd800 && (v < 10'd599 || v == 10'd627)) begin
            nl = (v == 10'd627) ? 0 : int'(v) + 1;
            if (fetch_ok) check("reads_per_line", 64'(rd_count), 64'd200);
            line_q.delete();
            for (int i = 0; i < 200; i++) line_q.push_back(mem[nl * 200 + i]);
            exp_rd_addr = 17'(nl * 200);
            rd_count = 0;
            fetch_ok = 1'b1;
        end
        if (h < 11'd800 && v < 10'd600) begin
            e_de = 1'b1;
            if (h[1:0] == 2'd0) begin
                if (line_q.size() == 0) begin
                    cur_word = '0;
                    e_uf = 1'b1;
                end else begin
                    cur_word = line_q.pop_front();
                end
            end
            e_pix = cur_word[8 * h[1:0] +: 8];
        end else begin
            e_de  = 1'b0;
            e_pix = '0;
        end
    endtask

    task automatic step(input logic [10:0] h, input logic [9:0] v, input bit do_rst);
        logic [48:0] exp_w;
        if (do_rst) begin
            reset = 1'b1;
            #1;
            check("rst_pixel", 64'(pixel), 64'd0);
            check("rst_de", 64'(de), 64'd0);
            check("rst_underflow", 64'(underflow), 64'd0);
            check("rst_mem_en", 64'(mem_en), 64'd0);
            check("rst_wr_gnt", 64'(wr_gnt), 64'd0);
            check("rst_fsm_idle", 64'(fsm_state), 64'd0);
            line_q.delete();
            e_uf = 1'b0;
            fetch_ok = 1'b0;
            cur_word = '0;
            prev_gnt = 1'b0;
        end
        hcount = h;
        vcount = v;
        ap_h = h;
        ap_v = v;
        model_apply(h, v);
        @(posedge clk);
        #1;
        if (do_rst) begin
            check("rst_hold_mem_en", 64'(mem_en), 64'd0);
            check("rst_hold_fsm", 64'(fsm_state), 64'd0);
            reset = 1'b0;
        end
        check("pixel", 64'(pixel), 64'(e_pix));
        check("de", 64'(de), 64'(e_de));
        check("underflow", 64'(underflow), 64'(e_uf));
        if (capture_on && ap_v <= 10'd4 && ap_h < 11'd800) obs[ap_v][ap_h] = pixel;
        check("gnt_vs_write", 64'(wr_gnt), 64'(mem_en && mem_we));
        if (mem_en && !mem_we) begin
            check("rd_addr", 64'(mem_addr), 64'(exp_rd_addr));
            exp_rd_addr = exp_rd_addr + 17'd1;
            rd_count++;
        end
        if (wr_gnt) begin
            check("gnt_spacing", 64'(prev_gnt), 64'd0);
            check("wr_q_size", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(exp_w[48:32]));
                check("wr_data", 64'(mem_wdata), 64'(exp_w[31:0]));
            end
            wr_req = 1'b0;
        end
        prev_gnt = wr_gnt;
        if (!wr_req && writer_on) new_request();
    endtask

    initial begin
        vecs[0]  = '{0, 0, 8'h00};   vecs[1]  = '{0, 1, 8'h01};
        vecs[2]  = '{0, 4, 8'h01};   vecs[3]  = '{0, 799, 8'hCA};
        vecs[4]  = '{1, 0, 8'hDD};   vecs[5]  = '{1, 1, 8'hCC};
        vecs[6]  = '{1, 2, 8'hBB};   vecs[7]  = '{1, 3, 8'hAA};
        vecs[8]  = '{1, 4, 8'hC9};   vecs[9]  = '{1, 799, 8'h92};
        vecs[10] = '{2, 10, 8'h94};  vecs[11] = '{3, 0, 8'h00};
        vecs[12] = '{3, 400, 8'h00}; vecs[13] = '{4, 0, 8'h20};
        vecs[14] = '{4, 5, 8'h22};

        for (int n = 0; n < 131072; n++) begin
            logic [7:0] b;
            b = n[7:0];
            mem[n] = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        end

        n_cmp = 0; n_err = 0;
        reset = 1'b1; hcount = '0; vcount = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        e_pix = '0; e_de = 1'b0; e_uf = 1'b0; cur_word = '0;
        exp_rd_addr = '0; rd_count = 0; fetch_ok = 1'b0; prev_gnt = 1'b0;
        ap_h = '0; ap_v = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pixel", 64'(pixel), 64'd0);
        check("reset_de", 64'(de), 64'd0);
        check("reset_underflow", 64'(underflow), 64'd0);
        check("reset_mem_en", 64'(mem_en), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        check("reset_wr_gnt", 64'(wr_gnt), 64'd0);
        check("reset_fsm", 64'(fsm_state), 64'd0);
        reset = 1'b0;

        writer_on = 1'b1;
        directed_pending = 1'b1;
        capture_on = 1'b1;
        for (int s = 0; s < 12; s++) begin
            if (s == 7) capture_on = 1'b0;
            for (int h = 0; h < 1056; h++)
                step(11'(h), 10'(lines[s]), (s == 4) && (h == 900));
        end

        writer_on = 1'b0;
        for (int k = 0; k < 50 && wr_req; k++) step(11'd900, 10'd600, 1'b0);
        check("writer_drained", 64'(wr_req), 64'd0);
        check("wr_q_empty", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 15; i++)
            check($sformatf("pix_y%0d_x%0d", vecs[i].y, vecs[i].x),
                  64'(obs[vecs[i].y][vecs[i].x]), 64'(vecs[i].pix));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_fb_fetch_arbiter.md
# vga_fb_fetch_arbiter

Frame-buffer controller for the SVGA 800x600 display path (40 MHz, 1056x628 total timing). It shares one single-port frame-buffer memory between two clients: the display line prefetcher, which has hard real-time priority, and a drawing-client write port. It prefetches packed pixel words into a small FIFO ahead of the active region. It unpacks them into one 8-bit RGB332 pixel per clock, aligned with the registered sync outputs of the horizontal and vertical counters.

## Interface
- H_DISPLAY, 800, active pixels per line
- V_DISPLAY, 600, active lines per frame
- H_TOTAL, 1056, clocks per line
- V_TOTAL, 628, lines per frame
- FIFO_DEPTH, 8, display word FIFO depth (power of 2, >= 4)
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- hcount  in  11  horizontal position from the H counter
- vcount  in  10  vertical position from the V counter
- wr_req  in  1  writer request; held with wr_addr/wr_data until wr_gnt
- wr_addr  in  17  word address (0..119999)
- wr_data  in  32  four packed pixels
- wr_gnt  out  1  one-cycle pulse: the write was issued to memory
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  1 = write, 0 = read, registered
- mem_addr  out  17  registered
- mem_wdata  out  32  registered
- mem_rdata  in  32  read data, valid exactly 1 cycle after the mem_en read cycle
- pixel  out  8  RGB332 pixel, 0 when not enabled
- de  out  1  display enable
- underflow  out  1  sticky display FIFO underflow flag

## Operation
- Packing:
  - Word = 4 pixels.
  - Bits [7:0] = x%4==0, up to bits [31:24] = x%4==3.
  - Line base address = line*200.
- Line fetch trigger at hcount==H_DISPLAY:
  - next_line = vcount+1 when vcount < V_DISPLAY-1.
  - next_line = 0 when vcount == V_TOTAL-1.
  - Otherwise no fetch.
- FSM states: IDLE, FLUSH, FETCH.
  - IDLE -> FLUSH on trigger.
  - FLUSH lasts 2 cycles. It issues no reads, discards returning read data, and clears the FIFO, the shift register and the word counter.
  - FLUSH -> FETCH, with fetch address set to next_line*200.
  - In FETCH, a read is issued whenever occupancy + in-flight < FIFO_DEPTH. The address increments per read.
  - FETCH -> IDLE after the 200th read issues.
- Arbitration, decided each cycle:
  - A display read (FETCH and space available) wins.
  - Otherwise a write is issued if wr_req=1 and wr_gnt is not high this cycle. This limits the writer to one write per 2 cycles and prevents double-issue.
  - Otherwise mem_en=0.
- Write issue: the decision is registered onto mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, with wr_gnt=1 in the same cycle. The writer may change its request after that edge.
- Pixel path:
  - Active when hcount<H_DISPLAY and vcount<V_DISPLAY.
  - At hcount%4==0, pop one word into the shift register; then shift 8 bits per clock.
  - If the FIFO is empty at a pop, output pixel=0 for those 4 pixels and set underflow=1. The flag is cleared only by reset.
- Address arithmetic: 17-bit unsigned. Writer addresses >= 120000 are issued unchanged; memory behaviour for them is not this block's concern.
- Reset, asynchronous:
  - All outputs 0; FSM IDLE; FIFO empty; in-flight count 0; underflow 0.
  - A mid-fetch reset aborts the line; that line displays as underflow zeros.

## Timing
- pixel/de are registered and correspond to the (hcount,vcount) of the previous cycle, matching the registered vsync.
- Read request in decision cycle t:
  - mem_en high in cycle t+1.
  - mem_rdata valid in t+2, pushed into the FIFO at the end of t+2.
  - In-flight count is at most 2.
- Fetch start to first word ready: 4 cycles. The 256-cycle blanking gap guarantees a full FIFO before hcount wraps to 0.
- Steady state uses 1 read per 4 clocks. The writer gets every other non-display slot.
- Simultaneous trigger and wr_req: FLUSH issues no reads, so the writer is granted.

## Test plan
- Reset mid-FETCH:
  - Stimulus: assert reset at hcount=900.
  - Response: all outputs 0 next cycle; FSM IDLE; next trigger refetches normally.
- Frame fill:
  - Stimulus: preload memory word n = {n[7:0]+3, +2, +1, +0} pattern; run 2 frames.
  - Response: pixel at (x,y) equals the expected byte of word y*200+x/4; de high for exactly 800x600 cycles per frame; underflow stays 0.
- Writer priority:
  - Stimulus: wr_req held continuously during active video.
  - Response: exactly 200 reads per line; writes in remaining slots; no back-to-back wr_gnt; no underflow.
- Write-then-display:
  - Stimulus: write 0xAABBCCDD to address 200 (line 1, x 0..3) during frame 0 blanking.
  - Response: line 1 pixels 0..3 = DD, CC, BB, AA.
- Forced underflow:
  - Stimulus: force mem_rdata late by holding the FSM in FLUSH (test hook) across hcount wrap.
  - Response: pixel=0 for the affected words; underflow=1 and stays 1; next line recovers.
- Frame wrap:
  - Stimulus: vcount=627 at hcount=800.
  - Response: fetch begins at address 0; line 0 displays correctly.
